// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants, counter widths
// and colour-bar helpers shared by the timing generator.
package vga_timing_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam logic [7:0] BAR_ON  = 8'hFF;
    localparam logic [7:0] BAR_OFF = 8'h00;

    function automatic int h_total(input int vis, input int fp,
                                   input int sy, input int bp);
        return vis + fp + sy + bp;
    endfunction

    function automatic int v_total(input int vis, input int fp,
                                   input int sy, input int bp);
        return vis + fp + sy + bp;
    endfunction

    // white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [23:0] bar_rgb(input logic [2:0] bar);
        return {bar[1] ? BAR_OFF : BAR_ON,
                bar[2] ? BAR_OFF : BAR_ON,
                bar[0] ? BAR_OFF : BAR_ON};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: N-deep shift register (N=0 is a wire) that re-times
// raster control bits to the pixel source latency.
module vga_sync_delay #(
    parameter int           N       = 2,
    parameter int           W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         pclk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (N == 0) begin : g_pass
            logic unused_clk;
            assign unused_clk = pclk ^ resetn;
            assign q = d;
        end else begin : g_dly
            logic [W-1:0] sr [N];

            always_ff @(posedge pclk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < N; i++) sr[i] <= RST_VAL;
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
                end
            end

            assign q = sr[N-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, coordinate outputs and latency-aligned
// VGA/HDMI drive. Define VGA_TESTPATTERN_EN to replace in_* by colour bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE     = DEF_H_VISIBLE,
    parameter int   H_FRONT       = DEF_H_FRONT,
    parameter int   H_SYNC        = DEF_H_SYNC,
    parameter int   H_BACK        = DEF_H_BACK,
    parameter int   V_VISIBLE     = DEF_V_VISIBLE,
    parameter int   V_FRONT       = DEF_V_FRONT,
    parameter int   V_SYNC        = DEF_V_SYNC,
    parameter int   V_BACK        = DEF_V_BACK,
    parameter logic HSYNC_POL     = 1'b0,
    parameter logic VSYNC_POL     = 1'b0,
    parameter int   PIXEL_LATENCY = 2
) (
    input  logic           pclk,
    input  logic           resetn,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           active,
    output logic           line_start,
    output logic           frame_start,
    input  logic [7:0]     in_red,
    input  logic [7:0]     in_green,
    input  logic [7:0]     in_blue,
    output logic [7:0]     out_vga_red,
    output logic [7:0]     out_vga_green,
    output logic [7:0]     out_vga_blue,
    output logic           out_vga_blank,
    output logic           out_vga_hsync,
    output logic           out_vga_vsync
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [X_W-1:0] H_VIS  = X_W'(H_VISIBLE);
    localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] HS_ON  = X_W'(H_VISIBLE + H_FRONT);
    localparam logic [X_W-1:0] HS_OFF = X_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [Y_W-1:0] V_VIS  = Y_W'(V_VISIBLE);
    localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] VS_ON  = Y_W'(V_VISIBLE + V_FRONT);
    localparam logic [Y_W-1:0] VS_OFF = Y_W'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [2:0] CTL_RST = {~HSYNC_POL, ~VSYNC_POL, 1'b1};

    logic [X_W-1:0] hc;
    logic [Y_W-1:0] vc;
    logic           hsync_t;
    logic           vsync_t;
    logic [2:0]     ctl_d;
    logic [23:0]    src_rgb;

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    // Everything at reference T is registered from hc/vc together.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync_t     <= ~HSYNC_POL;
            vsync_t     <= ~VSYNC_POL;
        end else begin
            x           <= hc;
            y           <= vc;
            active      <= (hc < H_VIS) && (vc < V_VIS);
            line_start  <= (hc == '0);
            frame_start <= (hc == '0) && (vc == '0);
            hsync_t     <= (hc >= HS_ON && hc < HS_OFF) ? HSYNC_POL
                                                        : ~HSYNC_POL;
            vsync_t     <= (vc >= VS_ON && vc < VS_OFF) ? VSYNC_POL
                                                        : ~VSYNC_POL;
        end
    end

    vga_sync_delay #(
        .N       (PIXEL_LATENCY),
        .W       (3),
        .RST_VAL (CTL_RST)
    ) u_ctl_dly (
        .pclk   (pclk),
        .resetn (resetn),
        .d      ({hsync_t, vsync_t, ~active}),
        .q      (ctl_d)
    );

`ifdef VGA_TESTPATTERN_EN
    logic [2:0] bar_t;
    logic [2:0] bar_d;
    logic       unused_in;

    assign unused_in = ^{in_red, in_green, in_blue};

    always_comb begin
        bar_t = '0;
        for (int k = 1; k < 8; k++) begin
            if (x >= X_W'(k * H_VISIBLE / 8)) bar_t = 3'(k);
        end
    end

    vga_sync_delay #(
        .N       (PIXEL_LATENCY),
        .W       (3),
        .RST_VAL (3'd0)
    ) u_bar_dly (
        .pclk   (pclk),
        .resetn (resetn),
        .d      (bar_t),
        .q      (bar_d)
    );

    assign src_rgb = bar_rgb(bar_d);
`else
    assign src_rgb = {in_red, in_green, in_blue};
`endif

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            out_vga_red   <= '0;
            out_vga_green <= '0;
            out_vga_blue  <= '0;
            out_vga_blank <= 1'b1;
            out_vga_hsync <= ~HSYNC_POL;
            out_vga_vsync <= ~VSYNC_POL;
        end else begin
            out_vga_hsync <= ctl_d[2];
            out_vga_vsync <= ctl_d[1];
            out_vga_blank <= ctl_d[0];
            {out_vga_red, out_vga_green, out_vga_blue} <=
                ctl_d[0] ? 24'h0 : src_rgb;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: raster model checked every cycle against a latency-2
// instance and a latency-0 / positive-hsync instance (short frames).
module tb_vga_timing_gen;

    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 24, VF = 3, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam logic [23:0] BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic pclk = 1'b0;
    logic resetn;
    logic [7:0] in_red, in_green, in_blue;
    logic [23:0] in_at;
    int n;
    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    logic [10:0] a_x, b_x;
    logic [9:0]  a_y, b_y;
    logic a_act, a_ls, a_fs, a_bl, a_hs, a_vs;
    logic b_act, b_ls, b_fs, b_bl, b_hs, b_vs;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .pclk(pclk), .resetn(resetn),
        .x(a_x), .y(a_y), .active(a_act),
        .line_start(a_ls), .frame_start(a_fs),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_vga_red(a_r), .out_vga_green(a_g), .out_vga_blue(a_b),
        .out_vga_blank(a_bl), .out_vga_hsync(a_hs), .out_vga_vsync(a_vs)
    );

    vga_timing_gen #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b1), .PIXEL_LATENCY(0)
    ) dut0 (
        .pclk(pclk), .resetn(resetn),
        .x(b_x), .y(b_y), .active(b_act),
        .line_start(b_ls), .frame_start(b_fs),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_vga_red(b_r), .out_vga_green(b_g), .out_vga_blue(b_b),
        .out_vga_blank(b_bl), .out_vga_hsync(b_hs), .out_vga_vsync(b_vs)
    );

    // n = rising edges seen since reset released
    always @(posedge pclk or negedge resetn) begin
        if (!resetn) n <= 0;
        else n <= n + 1;
    end

    always @(posedge pclk) in_at <= {in_red, in_green, in_blue};

    task automatic drive_in();
        if (n >= 800 && n < 1700) begin
            {in_red, in_green, in_blue} = 24'hABABAB;
        end else begin
            in_red   = n[7:0];
            in_green = ~n[7:0];
            in_blue  = 8'h3C;
        end
    endtask

    always @(posedge pclk) begin
        #1;
        drive_in();
    end

    task automatic check(input string nm, input int lat,
                         input bit hp, input bit vp,
                         input logic [10:0] x, input logic [9:0] y,
                         input logic act, input logic ls, input logic fs,
                         input logic [23:0] rgb, input logic bl,
                         input logic hs, input logic vs);
        int t, t2, cx, cy, ox, oy;
        logic [10:0] ex;
        logic [9:0] ey;
        logic ea, els, efs, ebl, ehs, evs;
        logic [23:0] ergb;
        ex = '0; ey = '0; ea = 0; els = 0; efs = 0;
        ebl = 1'b1; ehs = ~hp; evs = ~vp; ergb = '0;
        if (resetn && n > 0) begin
            t = n - 1;
            cx = t % HT;
            cy = (t / HT) % VT;
            ex = 11'(cx);
            ey = 10'(cy);
            ea = (cx < HV) && (cy < VV);
            els = (cx == 0);
            efs = (cx == 0) && (cy == 0);
        end
        t2 = n - lat - 2;
        if (resetn && t2 >= 0) begin
            ox = t2 % HT;
            oy = (t2 / HT) % VT;
            ebl = !((ox < HV) && (oy < VV));
            ehs = (ox >= HV + HF && ox < HV + HF + HS) ? hp : ~hp;
            evs = (oy >= VV + VF && oy < VV + VF + VS) ? vp : ~vp;
`ifdef VGA_TESTPATTERN_EN
            if (!ebl) ergb = BARS[ox * 8 / HV];
`else
            if (!ebl) ergb = in_at;
`endif
        end
        vectors++;
        if ({x, y, act, ls, fs, rgb, bl, hs, vs} !==
            {ex, ey, ea, els, efs, ergb, ebl, ehs, evs}) begin
            miscompares++;
            $display("FAIL %s n=%0d got x=%0d y=%0d a%b l%b f%b rgb=%h b%b h%b v%b want x=%0d y=%0d a%b l%b f%b rgb=%h b%b h%b v%b",
                     nm, n, x, y, act, ls, fs, rgb, bl, hs, vs,
                     ex, ey, ea, els, efs, ergb, ebl, ehs, evs);
        end
    endtask

    task automatic pin(input string nm, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL pin %s n=%0d got %0h want %0h", nm, n, got, want);
        end
    endtask

    task automatic pins();
        case (n)
            1: begin
                pin("x0", int'(a_x), 0); pin("y0", int'(a_y), 0);
                pin("fs0", int'(a_fs), 1); pin("ls0", int'(a_ls), 1);
                pin("act0", int'(a_act), 1); pin("L0_bl1", int'(b_bl), 1);
            end
            2: begin
                pin("L0_bl2", int'(b_bl), 0);
`ifdef VGA_TESTPATTERN_EN
                pin("L0_rgb2", int'({b_r, b_g, b_b}), 'hFFFFFF);
`else
                pin("L0_rgb2", int'({b_r, b_g, b_b}), 'h01FE3C);
`endif
            end
            3: pin("bl3", int'(a_bl), 1);
            4: begin
                pin("bl4", int'(a_bl), 0);
`ifdef VGA_TESTPATTERN_EN
                pin("rgb4", int'({a_r, a_g, a_b}), 'hFFFFFF);
`else
                pin("rgb4", int'({a_r, a_g, a_b}), 'h03FC3C);
`endif
            end
`ifdef VGA_TESTPATTERN_EN
            84:  pin("bar80", int'({a_r, a_g, a_b}), 'hFFFF00);
            484: pin("bar480", int'({a_r, a_g, a_b}), 'h0000FF);
            564: pin("bar560", int'({a_r, a_g, a_b}), 'h000000);
`else
            84:  pin("rgb84", int'({a_r, a_g, a_b}), 'h53AC3C);
`endif
            643: pin("bl_x639", int'(a_bl), 0);
            644: begin
                pin("bl_x640", int'(a_bl), 1);
                pin("rgb_x640", int'({a_r, a_g, a_b}), 0);
            end
            657: pin("L0_hs_off", int'(b_hs), 0);
            658: pin("L0_hs_on", int'(b_hs), 1);
            659: pin("hs_pre", int'(a_hs), 1);
            660: pin("hs_on", int'(a_hs), 0);
            753: pin("L0_hs_last", int'(b_hs), 1);
            754: pin("L0_hs_end", int'(b_hs), 0);
            755: pin("hs_last", int'(a_hs), 0);
            756: pin("hs_end", int'(a_hs), 1);
            800: pin("ls799", int'(a_ls), 0);
            801: begin
                pin("ls800", int'(a_ls), 1);
                pin("y_line1", int'(a_y), 1);
            end
`ifdef VGA_TESTPATTERN_EN
            804:  pin("rgb_l1_x0", int'({a_r, a_g, a_b}), 'hFFFFFF);
            1443: pin("bar639", int'({a_r, a_g, a_b}), 'h000000);
`else
            804:  pin("rgb_l1_x0", int'({a_r, a_g, a_b}), 'hABABAB);
            1443: pin("rgb_l1_x639", int'({a_r, a_g, a_b}), 'hABABAB);
`endif
            1444:  pin("rgb_l1_x640", int'({a_r, a_g, a_b}), 0);
            21603: pin("vs_pre", int'(a_vs), 1);
            21604: pin("vs_on", int'(a_vs), 0);
            23203: pin("vs_last", int'(a_vs), 0);
            23204: pin("vs_end", int'(a_vs), 1);
            25600: begin
                pin("y_last", int'(a_y), VT - 1);
                pin("fs_pre", int'(a_fs), 0);
            end
            25601: begin
                pin("y_wrap", int'(a_y), 0);
                pin("fs_wrap", int'(a_fs), 1);
            end
            default: ;
        endcase
    endtask

    always @(negedge pclk) begin
        if (chk_en) begin
            check("L2", 2, 1'b0, 1'b0, a_x, a_y, a_act, a_ls, a_fs,
                  {a_r, a_g, a_b}, a_bl, a_hs, a_vs);
            check("L0", 0, 1'b1, 1'b0, b_x, b_y, b_act, b_ls, b_fs,
                  {b_r, b_g, b_b}, b_bl, b_hs, b_vs);
            if (resetn) pins();
        end
    end

    initial begin
        resetn = 1'b1;
        drive_in();
        #1 resetn = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge pclk);
        #2 resetn = 1'b1;

        // run into frame 2 and stop at x=300, y=20
        for (int i = 0; i < 60000 && n != 41901; i++) @(negedge pclk);
        vectors++;
        if (n != 41901) begin
            miscompares++;
            $display("FAIL reach_midline n=%0d want 41901", n);
        end
        pin("mid_x", int'(a_x), 300);
        pin("mid_y", int'(a_y), 20);

        #2 resetn = 1'b0;
        #1;
        pin("async_x", int'(a_x), 0);
        pin("async_bl", int'(a_bl), 1);
        check("L2async", 2, 1'b0, 1'b0, a_x, a_y, a_act, a_ls, a_fs,
              {a_r, a_g, a_b}, a_bl, a_hs, a_vs);
        check("L0async", 0, 1'b1, 1'b0, b_x, b_y, b_act, b_ls, b_fs,
              {b_r, b_g, b_b}, b_bl, b_hs, b_vs);
        @(negedge pclk);
        #2 resetn = 1'b1;
        repeat (1000) @(negedge pclk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-clock-domain raster timing generator; sits directly upstream of the HDMI/TMDS output stage.
- Produces pixel coordinates for the pixel source (framebuffer, sprite or game logic).
- Accepts that source's RGB a fixed PIXEL_LATENCY cycles later and re-aligns hsync/vsync/blank so all three drive the HDMI stage inputs cycle-coherently.
- Default timing is 640x480@60 (25.175 MHz pclk).

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pclk)
- H_SYNC, 96, hsync width (pclk)
- H_BACK, 48, horizontal back porch (pclk)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- PIXEL_LATENCY, 2, cycles from coordinate output to in_* RGB valid; range 0..15

Ports:
- pclk  input  1  pixel clock; all logic on rising edge
- resetn  input  1  asynchronous active-low reset
- x  output  11  current column, 0..H_TOTAL-1
- y  output  10  current row, 0..V_TOTAL-1
- active  output  1  x<H_VISIBLE and y<V_VISIBLE, aligned with x/y
- line_start  output  1  one-cycle pulse when x==0
- frame_start  output  1  one-cycle pulse when x==0 and y==0
- in_red/in_green/in_blue  input  8 each  source RGB for the coordinate issued PIXEL_LATENCY cycles earlier
- out_vga_red/out_vga_green/out_vga_blue  output  8 each  to HDMI stage
- out_vga_blank  output  1  1 outside visible area
- out_vga_hsync, out_vga_vsync  output  1 each  sync, polarity per parameters

Behaviour:
- Totals: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800 and 525.
- Ordering: visible region, then front porch, sync, back porch; the counters start at the first visible pixel.
- Horizontal counter hc: increments every cycle. At hc==H_TOTAL-1 it wraps to 0 and the vertical counter vc increments.
- Vertical counter vc: wraps to 0 at V_TOTAL-1 when hc wraps.
- Coordinate outputs: x, y, active, line_start and frame_start are registered outputs of hc/vc and share one timing reference T.
- Raw signals, valid at T:
  - hsync asserted for H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC.
  - vsync asserted for V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC.
  - vsync transitions at hc==0.
  - blank = ~active.
- Alignment: raw hsync, vsync and blank pass through a PIXEL_LATENCY-deep shift register. in_* is sampled at T+PIXEL_LATENCY. All out_vga_* are registered once more, so they are valid at T+PIXEL_LATENCY+1.
- PIXEL_LATENCY=0: delay line is absent; in_* is sampled in the same cycle as x/y.
- Blanking: out_vga_red/green/blue are forced to 0 whenever the delayed blank is 1, whatever the value of in_*.
- Reset (asynchronous, any cycle, including mid-line):
  - hc=vc=0.
  - Delay line cleared to blank=1 and sync at deasserted level.
  - out RGB=0, out_vga_blank=1, syncs deasserted (~HSYNC_POL, ~VSYNC_POL).
  - x=y=0, active=0, line_start=0, frame_start=0.
- Release: on the first pclk edge after resetn rises, x=0, y=0, line_start=1, frame_start=1, active=1. The first frame is a full frame.
- Outputs depend on no input other than in_*. There is no backpressure; the source must meet PIXEL_LATENCY exactly.

Optional Feature:
- Macro: VGA_TESTPATTERN_EN.
- Defined: in_* are ignored and replaced by internal 8-bar colour bars.
  - bar = floor(x_delayed*8/H_VISIBLE), computed by comparing against 7 constant thresholds (no divider).
  - R = 8×~bar[1], G = 8×~bar[2], B = 8×~bar[0], each bit replicated across 8 bits.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Same latency and blanking rules as normal operation.
- Undefined: RGB comes from in_*; no pattern logic is synthesised.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants for 640x480@60;
  - derived H_TOTAL/V_TOTAL functions;
  - counter width constants (11/10);
  - colour-bar RGB constants.
- Sub-module vga_sync_delay: parameterised depth N (0..15), width 3 (hsync, vsync, blank), async active-low reset to a per-bit reset value, N=0 passthrough.

Test Plan:
- Reset release, defaults -> first cycle x=0, y=0, frame_start=1; out_vga_blank=1 until cycle PIXEL_LATENCY+1 (=3), then 0 with RGB = in_* sampled at cycle 2.
- Run one line -> hsync low exactly at T-relative hc 656..751 (96 cycles, delayed by 3); blank high for hc 640..799; line_start period 800.
- Run full frame -> vsync low for lines 490..491, edges at hc==0 (+3 delay); frame_start period 420000 cycles; y wraps 524->0.
- in_*=8'hAB constant -> out RGB=AB during visible, 00 during every blanked cycle, including the first and last visible pixel boundaries.
- Assert resetn low at x=300, y=200 for 1 cycle -> all outputs go to reset values asynchronously; restart at x=0, y=0.
- VGA_TESTPATTERN_EN defined -> visible pixel x=0 gives FFFFFF, x=80 gives FFFF00, x=639 gives 000000, x=560 gives 000000, x=480 gives 0000FF.
- PIXEL_LATENCY=0 build -> out_vga_* lags x/y by exactly 1 cycle.
